// File: rtl/bcd_phase_timer_pkg.sv
// Shared types and constants for the irrigation phase timer.
// Latency: none (declarations only).
// Backpressure: none.
package irrigation_timer_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Out-of-range nibbles (A..F) are clamped to 9 so the count is always valid BCD.
  function automatic logic [3:0] sanitise_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_phase_timer_if.sv
// Control/status bundle between a phase sequencer and one phase timer.
// Latency: none (wires only).
// Backpressure: none; level-sampled controls, registered status.
interface bcd_phase_timer_if
  import irrigation_timer_pkg::*;
#(
  parameter int DIGITS = 3
) ();

  logic                    start;
  logic                    pause;
  logic                    abort;
  logic [BCD_W*DIGITS-1:0] preset;
  logic [BCD_W*DIGITS-1:0] bcd;
  logic                    busy;
  logic                    paused;
  logic                    done;

  modport master (
    output start, pause, abort, preset,
    input  bcd, busy, paused, done
  );

  modport slave (
    input  start, pause, abort, preset,
    output bcd, busy, paused, done
  );

endinterface

// File: rtl/bcd_phase_timer_digit_down.sv
// One BCD digit of a ripple-borrow down-counter.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_down
  import irrigation_timer_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  // Decrement when borrowed from; 0 wraps to 9 and passes the borrow upward.
  always_comb begin
    digit_next = digit;
    if (borrow_in) begin
      digit_next = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/bcd_phase_timer.sv
// Multi-digit BCD phase timer: load preset, count down one step per TICK_DIV clocks, pulse done at zero.
// Latency: load/abort/pause visible one cycle after the sampling edge; first decrement TICK_DIV edges after load.
// Backpressure: none; pause freezes count and prescaler, abort clears, start ignored while busy.
module bcd_phase_timer
  import irrigation_timer_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  bcd_phase_timer_if.slave  io
);

  localparam int            CW       = BCD_W * DIGITS;
  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_dec;
  logic [CW-1:0]   preset_clean;
  logic [PW-1:0]   pre_q;
  logic [PW-1:0]   pre_d;
  logic            done_q;
  logic            done_d;
  logic [DIGITS:0] borrow;
  logic            load;
  logic            counting;
  logic            tick;
  logic            step;
  logic            cnt_zero;
  logic            dec_zero;
  logic            preset_zero;

  // Digit chain: borrow enters digit 0 unconditionally; the result is only
  // committed on a tick, so the chain doubles as the all-zero detector.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign preset_clean[i*BCD_W +: BCD_W] = sanitise_digit(io.preset[i*BCD_W +: BCD_W]);

    bcd_digit_down u_digit (
      .digit      (cnt_q[i*BCD_W +: BCD_W]),
      .borrow_in  (borrow[i]),
      .digit_next (cnt_dec[i*BCD_W +: BCD_W]),
      .borrow_out (borrow[i+1])
    );
  end

  // A borrow escaping the top digit means every digit was zero.
  assign cnt_zero    = borrow[DIGITS];
  assign dec_zero    = (cnt_dec == '0);
  assign preset_zero = (io.preset == '0);

  // Prescaler advances in RUN, and also on the edge leaving PAUSE, so a pause
  // of N sampled cycles stretches the phase by exactly N cycles.
  assign load     = (state_q == IDLE) && io.start && !io.abort;
  assign counting = (state_q != IDLE) && !io.pause && !io.abort;
  assign tick     = counting && (pre_q == PRE_LAST);
  assign step     = tick && !cnt_zero;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort first, then load, then pause, then terminal tick.
  always_comb begin
    state_d = state_q;
    if (io.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.start && !preset_zero) state_d = RUN;
        end
        RUN, PAUSE: begin
          if (io.pause)                state_d = PAUSE;
          else if (step && dec_zero)   state_d = IDLE;
          else                         state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: count, prescaler and the one-cycle done pulse.
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    done_d = 1'b0;
    if (io.abort) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (load) begin
      cnt_d  = preset_clean;
      pre_d  = '0;
      done_d = preset_zero;
    end else if (counting) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (step) begin
        cnt_d  = cnt_dec;
        done_d = dec_zero;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      done_q <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    io.bcd    = cnt_q;
    io.busy   = (state_q != IDLE);
    io.paused = (state_q == PAUSE);
    io.done   = done_q;
  end

endmodule

// File: tb/tb_bcd_phase_timer.sv
module tb_bcd_phase_timer;

  localparam int TD = 4;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  bcd_phase_timer_if #(.DIGITS(3)) io ();

  bcd_phase_timer #(.DIGITS(3), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal count, cycles since last step, status flags.
  typedef struct {
    int count;
    int phase;
    bit busy;
    bit paused;
    bit done;
  } model_t;

  model_t m;

  function automatic int clean_value(input logic [11:0] p);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 3; i++) begin
      int d = int'(p[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x = v;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input bit start, input bit pause,
                                        input bit abort, input logic [11:0] preset);
    model_t n = c;
    n.done = 1'b0;
    if (abort) begin
      n.count = 0; n.phase = 0; n.busy = 0; n.paused = 0;
    end else if (!c.busy) begin
      if (start) begin
        n.count = clean_value(preset);
        n.phase = 0;
        if (n.count == 0) n.done = 1'b1;
        else              n.busy = 1'b1;
      end
    end else if (pause) begin
      n.paused = 1'b1;
    end else begin
      n.paused = 1'b0;
      if (c.phase == TD - 1) begin
        n.phase = 0;
        n.count = c.count - 1;
        if (n.count == 0) begin
          n.busy = 1'b0;
          n.done = 1'b1;
        end
      end else begin
        n.phase = c.phase + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{count: 0, phase: 0, busy: 0, paused: 0, done: 0};
    else          m <= model_next(m, io.start, io.pause, io.abort, io.preset);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, plus BCD validity.
  always @(negedge clk) begin
    if (reset_n) begin
      check("model bcd",    32'(io.bcd),    32'(to_bcd(m.count)));
      check("model busy",   32'(io.busy),   32'(m.busy));
      check("model paused", 32'(io.paused), 32'(m.paused));
      check("model done",   32'(io.done),   32'(m.done));
      for (int i = 0; i < 3; i++) begin
        if (io.bcd[i*4 +: 4] > 4'd9) check("nibble valid", 32'(io.bcd[i*4 +: 4]), 32'd9);
      end
    end
  end

  task automatic do_load(input logic [11:0] p);
    io.preset = p;
    io.start  = 1'b1;
    @(negedge clk);
    io.start  = 1'b0;
  endtask

  task automatic do_abort();
    io.abort = 1'b1;
    @(negedge clk);
    io.abort = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int k);
    k = 0;
    while (k < bound) begin
      @(negedge clk);
      k++;
      if (io.done === 1'b1) break;
    end
  endtask

  initial begin
    int k;
    int k2;
    int pulses;
    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    io.start = 1'b0;
    io.pause = 1'b0;
    io.abort = 1'b0;
    io.preset = '0;
    #1;
    check("reset bcd",    32'(io.bcd),    32'h0);
    check("reset busy",   32'(io.busy),   32'h0);
    check("reset paused", 32'(io.paused), 32'h0);
    check("reset done",   32'(io.done),   32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain countdown 12 -> 0 at TICK_DIV=4.
    do_load(12'h012);
    check("load 012 bcd",  32'(io.bcd),  32'h012);
    check("load 012 busy", 32'(io.busy), 32'h1);
    wait_done(200, k);
    check("done latency 012", 32'(k), 32'd48);
    check("busy falls with done", 32'(io.busy), 32'h0);
    check("bcd zero at done", 32'(io.bcd), 32'h0);
    @(negedge clk);
    check("done one cycle", 32'(io.done), 32'h0);

    // Borrow across digits.
    do_load(12'h100);
    repeat (TD) @(negedge clk);
    check("borrow 100->099", 32'(io.bcd), 32'h099);
    repeat (TD) @(negedge clk);
    check("099->098", 32'(io.bcd), 32'h098);
    do_abort();

    // Pause for 10 cycles after two prescaler counts.
    do_load(12'h005);
    repeat (2) @(negedge clk);
    io.pause = 1'b1;
    repeat (10) @(negedge clk);
    check("pause holds bcd", 32'(io.bcd),    32'h005);
    check("paused flag",     32'(io.paused), 32'h1);
    check("busy in pause",   32'(io.busy),   32'h1);
    io.pause = 1'b0;
    @(negedge clk);
    check("resume no step yet", 32'(io.bcd), 32'h005);
    @(negedge clk);
    check("resume step",        32'(io.bcd), 32'h004);
    wait_done(100, k2);
    check("paused done latency", 32'(k2 + 14), 32'd30);

    // Abort together with start mid-count.
    do_load(12'h009);
    k = 0;
    while (io.bcd !== 12'h007 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached 007", 32'(io.bcd), 32'h007);
    io.abort  = 1'b1;
    io.start  = 1'b1;
    io.preset = 12'h123;
    @(negedge clk);
    io.abort = 1'b0;
    io.start = 1'b0;
    check("abort bcd",  32'(io.bcd),  32'h0);
    check("abort busy", 32'(io.busy), 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (io.done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("no done after abort", 32'(pulses), 32'd0);

    // Zero preset and out-of-range preset.
    do_load(12'h000);
    check("zero preset done", 32'(io.done), 32'h1);
    check("zero preset busy", 32'(io.busy), 32'h0);
    @(negedge clk);
    check("zero preset pulse ends", 32'(io.done), 32'h0);
    do_load(12'hF9A);
    check("sanitise F9A", 32'(io.bcd), 32'h999);
    do_abort();

    // Asynchronous reset mid-run, then restart.
    do_load(12'h050);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async reset bcd",  32'(io.bcd),  32'h0);
    check("async reset busy", 32'(io.busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_load(12'h003);
    wait_done(100, k);
    check("restart done latency", 32'(k), 32'd12);

    // Randomized control traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      io.abort  = ($urandom_range(0, 59) == 0);
      io.start  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) io.pause = ~io.pause;
      io.preset = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      @(negedge clk);
    end
    io.start = 1'b0;
    io.pause = 1'b0;
    io.abort = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
